seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 201 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/logic/shift ops plus WIDTH-iteration signed
// shift-add multiply and restoring divide sharing one datapath.
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   A_reg,
  input  logic [WIDTH-1:0]   B_reg,
  output logic [2*WIDTH-1:0] C_reg,
  output logic               busy,
  output logic               done,
  output logic               div_zero,
  output logic               illegal_op
);

  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpShr  = 5'b00111;
  localparam logic [4:0] OpShra = 5'b01000;
  localparam logic [4:0] OpShl  = 5'b01001;
  localparam logic [4:0] OpRor  = 5'b01010;
  localparam logic [4:0] OpRol  = 5'b01011;
  localparam logic [4:0] OpMul  = 5'b01111;
  localparam logic [4:0] OpDiv  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;

  localparam logic [SHW-1:0] LastCnt = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StIter, StFinish} state_e;

  state_e               r_state;
  logic [SHW-1:0]       r_cnt;
  logic                 r_is_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [2*WIDTH-1:0]   r_c;
  logic                 r_done;
  logic                 r_dz;
  logic                 r_ill;

  logic [SHW-1:0]       w_amt;
  logic [2*WIDTH-1:0]   w_dbl;
  logic [WIDTH-1:0]     w_ror;
  logic [WIDTH-1:0]     w_rol;
  logic [WIDTH-1:0]     w_res;
  logic                 w_ill;
  logic                 w_dz;
  logic                 w_multi;
  logic [2*WIDTH-1:0]   w_c_single;
  logic [WIDTH-1:0]     w_ma;
  logic [WIDTH-1:0]     w_mb;
  logic [WIDTH:0]       w_madd;
  logic [WIDTH:0]       w_dshift;
  logic [WIDTH:0]       w_dtrial;
  logic [WIDTH-1:0]     w_hi_nxt;
  logic [WIDTH-1:0]     w_lo_nxt;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;
  logic [2*WIDTH-1:0]   w_c_fin;

  assign w_amt = B_reg[SHW-1:0];
  // Rotates come from shifting A concatenated with itself.
  assign w_dbl = {A_reg, A_reg};
  assign w_ror = WIDTH'(w_dbl >> w_amt);
  assign w_rol = WIDTH'((w_dbl << w_amt) >> WIDTH);

  always_comb begin
    w_res   = '0;
    w_ill   = 1'b0;
    w_dz    = 1'b0;
    w_multi = 1'b0;
    case (opcode)
      OpAdd:  w_res = A_reg + B_reg;
      OpSub:  w_res = A_reg - B_reg;
      OpAnd:  w_res = A_reg & B_reg;
      OpOr:   w_res = A_reg | B_reg;
      OpShr:  w_res = A_reg >> w_amt;
      OpShra: w_res = $signed(A_reg) >>> w_amt;
      OpShl:  w_res = A_reg << w_amt;
      OpRor:  w_res = w_ror;
      OpRol:  w_res = w_rol;
      OpNeg:  w_res = -A_reg;
      OpNot:  w_res = ~A_reg;
      OpMul:  w_multi = 1'b1;
      OpDiv: begin
        if (B_reg == '0) w_dz = 1'b1;
        else             w_multi = 1'b1;
      end
      default: w_ill = 1'b1;
    endcase
  end

  assign w_c_single = w_dz ? {A_reg, {WIDTH{1'b1}}} : {{WIDTH{1'b0}}, w_res};

  // Magnitudes are unsigned, so the most negative value maps to 2^(WIDTH-1).
  assign w_ma = A_reg[WIDTH-1] ? -A_reg : A_reg;
  assign w_mb = B_reg[WIDTH-1] ? -B_reg : B_reg;

  // One shift-add or one restoring-divide step on {r_hi, r_lo}.
  always_comb begin
    w_madd   = '0;
    w_dshift = '0;
    w_dtrial = '0;
    w_hi_nxt = r_hi;
    w_lo_nxt = r_lo;
    if (r_is_div) begin
      w_dshift = {r_hi, r_lo[WIDTH-1]};
      w_dtrial = w_dshift - {1'b0, r_mcand};
      if (w_dtrial[WIDTH]) begin
        w_hi_nxt = w_dshift[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end else begin
        w_hi_nxt = w_dtrial[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end
    end else begin
      w_madd   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
      w_hi_nxt = w_madd[WIDTH:1];
      w_lo_nxt = {w_madd[0], r_lo[WIDTH-1:1]};
    end
  end

  assign w_prod  = {r_hi, r_lo};
  assign w_quo   = r_neg_q ? -r_lo : r_lo;
  assign w_rem   = r_neg_r ? -r_hi : r_hi;
  assign w_c_fin = r_is_div ? {w_rem, w_quo} : (r_neg_q ? -w_prod : w_prod);

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_mcand  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_c      <= '0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_ill    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_dz  <= w_dz;
            r_ill <= w_ill;
            if (w_multi) begin
              r_state  <= StIter;
              r_cnt    <= '0;
              r_is_div <= (opcode == OpDiv);
              r_neg_q  <= A_reg[WIDTH-1] ^ B_reg[WIDTH-1];
              r_neg_r  <= A_reg[WIDTH-1];
              r_mcand  <= w_mb;
              r_hi     <= '0;
              r_lo     <= w_ma;
            end else begin
              r_c    <= w_c_single;
              r_done <= 1'b1;
            end
          end
        end
        StIter: begin
          r_hi <= w_hi_nxt;
          r_lo <= w_lo_nxt;
          if (r_cnt == LastCnt) begin
            r_cnt   <= '0;
            r_state <= StFinish;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StFinish: begin
          r_c     <= w_c_fin;
          r_done  <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign C_reg      = r_c;
  assign busy       = (r_state != StIdle);
  assign done       = r_done;
  assign div_zero   = r_dz;
  assign illegal_op = r_ill;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=32): vector table plus clear/busy corner sequences.
module tb_seq_alu;

  localparam int unsigned W = 32;

  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b00101;
  localparam logic [4:0] OpOr   = 5'b00110;
  localparam logic [4:0] OpShr  = 5'b00111;
  localparam logic [4:0] OpShra = 5'b01000;
  localparam logic [4:0] OpShl  = 5'b01001;
  localparam logic [4:0] OpRor  = 5'b01010;
  localparam logic [4:0] OpRol  = 5'b01011;
  localparam logic [4:0] OpMul  = 5'b01111;
  localparam logic [4:0] OpDiv  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;

  logic           clk = 1'b0;
  logic           clear;
  logic           start;
  logic [4:0]     opcode;
  logic [W-1:0]   A_reg;
  logic [W-1:0]   B_reg;
  logic [2*W-1:0] C_reg;
  logic           busy;
  logic           done;
  logic           div_zero;
  logic           illegal_op;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk        (clk),
    .clear      (clear),
    .start      (start),
    .opcode     (opcode),
    .A_reg      (A_reg),
    .B_reg      (B_reg),
    .C_reg      (C_reg),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .illegal_op (illegal_op)
  );

  typedef struct {
    logic [4:0]    op;
    logic [31:0]   a;
    logic [31:0]   b;
    logic [63:0]   c;
    logic          dz;
    logic          ill;
    int            lat;  // edges after the accept edge until done is seen
  } vec_t;

  vec_t vecs[32];
  int   nv = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] c, input logic dz, input logic ill, input int lat);
    vecs[nv].op  = op;
    vecs[nv].a   = a;
    vecs[nv].b   = b;
    vecs[nv].c   = c;
    vecs[nv].dz  = dz;
    vecs[nv].ill = ill;
    vecs[nv].lat = lat;
    nv++;
  endtask

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    @(negedge clk);
    opcode = op;
    A_reg  = a;
    B_reg  = b;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  initial begin
    int  lat;
    bit  seen_done;
    bit  busy_ok;

    clear  = 1'b1;
    start  = 1'b0;
    opcode = '0;
    A_reg  = '0;
    B_reg  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_c", C_reg, 64'h0);
    check("reset_flags", {60'h0, busy, done, div_zero, illegal_op}, 64'h0);
    @(negedge clk);
    clear = 1'b0;

    add_vec(OpAdd,  32'h7FFF_FFFF, 32'h1,         64'h0000_0000_8000_0000, 0, 0, 0);
    add_vec(OpSub,  32'h0,         32'h1,         64'h0000_0000_FFFF_FFFF, 0, 0, 0);
    add_vec(OpAnd,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 64'h0000_0000_00F0_00F0, 0, 0, 0);
    add_vec(OpOr,   32'hF0F0_F0F0, 32'h0FF0_0FF0, 64'h0000_0000_FFF0_FFF0, 0, 0, 0);
    add_vec(OpShr,  32'h8000_0000, 32'h4,         64'h0000_0000_0800_0000, 0, 0, 0);
    add_vec(OpShra, 32'h8000_0000, 32'h4,         64'h0000_0000_F800_0000, 0, 0, 0);
    add_vec(OpShl,  32'h0000_0001, 32'h1F,        64'h0000_0000_8000_0000, 0, 0, 0);
    add_vec(OpShl,  32'h1234_5678, 32'h20,        64'h0000_0000_1234_5678, 0, 0, 0);
    add_vec(OpRor,  32'h0000_0001, 32'h1,         64'h0000_0000_8000_0000, 0, 0, 0);
    add_vec(OpRor,  32'h0000_0001, 32'h21,        64'h0000_0000_8000_0000, 0, 0, 0);
    add_vec(OpRol,  32'h8000_0001, 32'h4,         64'h0000_0000_0000_0018, 0, 0, 0);
    add_vec(OpNeg,  32'h8000_0000, 32'h0,         64'h0000_0000_8000_0000, 0, 0, 0);
    add_vec(OpNeg,  32'h0000_0005, 32'h0,         64'h0000_0000_FFFF_FFFB, 0, 0, 0);
    add_vec(OpNot,  32'h0F0F_0000, 32'h0,         64'h0000_0000_F0F0_FFFF, 0, 0, 0);
    add_vec(OpMul,  32'hFFFF_FFFD, 32'h7,         64'hFFFF_FFFF_FFFF_FFEB, 0, 0, 33);
    add_vec(OpMul,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 0, 0, 33);
    add_vec(OpMul,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 0, 33);
    add_vec(OpMul,  32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 0, 0, 33);
    add_vec(OpDiv,  32'hFFFF_FFF9, 32'h2,         64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 33);
    add_vec(OpDiv,  32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 0, 0, 33);
    add_vec(OpDiv,  32'd100,       32'd7,         64'h0000_0002_0000_000E, 0, 0, 33);
    add_vec(OpDiv,  32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, 0, 33);
    add_vec(OpDiv,  32'h0000_0005, 32'h0,         64'h0000_0005_FFFF_FFFF, 1, 0, 0);
    add_vec(5'b00000, 32'h1234,    32'h5678,      64'h0,                   0, 1, 0);
    add_vec(OpAdd,  32'h1,         32'h2,         64'h0000_0000_0000_0003, 0, 0, 0);
    add_vec(5'b11111, 32'hFFFF,    32'h1,         64'h0,                   0, 1, 0);
    add_vec(OpDiv,  32'hFFFF_FFFF, 32'h0,         64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
    add_vec(OpSub,  32'h0000_0010, 32'h0000_0003, 64'h0000_0000_0000_000D, 0, 0, 0);

    for (int i = 0; i < nv; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_c", i), C_reg, vecs[i].c);
      check($sformatf("v%0d_flags", i), {61'h0, busy, div_zero, illegal_op},
            {61'h0, 1'b0, vecs[i].dz, vecs[i].ill});
    end

    // Clear aborts an in-flight multiply with no done pulse.
    run_op(OpAdd, 32'h1, 32'h1, lat);
    @(negedge clk);
    opcode = OpMul;
    A_reg  = 32'h5;
    B_reg  = 32'h9;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_c", C_reg, 64'h0);
    check("abort_done", {63'h0, done}, 64'h0);
    @(negedge clk);
    clear = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) seen_done = 1'b1;
    end
    check("abort_no_done", {63'h0, seen_done}, 64'h0);

    // Start while busy is dropped; the multiply completes unchanged.
    @(negedge clk);
    opcode = OpMul;
    A_reg  = 32'h3;
    B_reg  = 32'h5;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    for (int i = 1; i <= 100 && !done; i++) begin
      if (!busy) busy_ok = 1'b0;
      if (i == 5) begin
        @(negedge clk);
        opcode = OpAdd;
        A_reg  = 32'h1;
        B_reg  = 32'h1;
        start  = 1'b1;
      end
      @(posedge clk);
      #1 start = 1'b0;
      lat = i;
    end
    check("drop_busy_held", {63'h0, busy_ok}, 64'h1);
    check("drop_latency", 64'(lat), 64'd33);
    check("drop_c", C_reg, 64'h0000_0000_0000_000F);

    // Clear wins over a simultaneous start.
    @(negedge clk);
    clear  = 1'b1;
    start  = 1'b1;
    opcode = OpAdd;
    A_reg  = 32'h1;
    B_reg  = 32'h2;
    @(posedge clk);
    #1;
    check("clr_start_c", C_reg, 64'h0);
    check("clr_start_done", {62'h0, done, busy}, 64'h0);
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
